interrupt_controller: RTL



---
 rtl/interrupt_pkg.sv | 23 ++
 rtl/irq_arbiter.sv | 45 ++++
 rtl/interrupt_controller.sv | 91 +++++++++
 3 files changed

// File: rtl/interrupt_pkg.sv
// Shared types and constants for the machine-mode interrupt controller.
// Optional feature: INTERRUPT_ROUND_ROBIN_EN selects round-robin arbitration
// instead of fixed lowest-index priority.
package interrupt_pkg;

    // Controller sequencing: take one request, strobe the trap, wait for mret,
    // then pulse completion back to the serviced line.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAP    = 2'd1,
        SERVICE = 2'd2,
        FIN     = 2'd3
    } irq_state_e;

    // mcause reported for line 0; line k reports CAUSE_BASE + k.
    localparam logic [31:0] CAUSE_BASE_DEFAULT = 32'h8000_0010;

    // Index width for n lines; a single line still needs one bit to hold it.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational picker: returns one pending line.
// INTERRUPT_ROUND_ROBIN_EN defined  : search upward from rr_ptr+1 with wrap.
// INTERRUPT_ROUND_ROBIN_EN undefined: lowest index wins, rr_ptr is unused.
module irq_arbiter
    import interrupt_pkg::*;
#(
    parameter int N_IRQ = 16,
    parameter int IDX_W = idx_w(N_IRQ)
) (
    input  logic [N_IRQ-1:0] pending,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

`ifdef INTERRUPT_ROUND_ROBIN_EN
    // First pending line after the last winner, wrapping at N_IRQ.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int off = 1; off <= N_IRQ; off++) begin
            if (!valid && pending[(int'(rr_ptr) + off) % N_IRQ]) begin
                valid = 1'b1;
                index = IDX_W'((int'(rr_ptr) + off) % N_IRQ);
            end
        end
    end
`else
    // Fixed priority: walk downward so the lowest set index is written last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (pending[k]) begin
                valid = 1'b1;
                index = IDX_W'(k);
            end
        end
    end

    logic rr_unused;
    assign rr_unused = ^rr_ptr;
`endif

endmodule

// File: rtl/interrupt_controller.sv
// Machine-mode interrupt controller sitting in front of the CSR file.
// Masks level requests with mie, strobes one trap with its mcause, holds the
// selection until mret, then pulses a one-hot completion to that line.
// Optional feature: INTERRUPT_ROUND_ROBIN_EN (round-robin arbitration with an
// rr_ptr register); when undefined, lowest index wins and no pointer exists.
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int          N_IRQ      = 16,
    parameter logic [31:0] CAUSE_BASE = CAUSE_BASE_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      mie_i,
    input  logic [N_IRQ-1:0] int_req_i,
    input  logic             mret_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] int_fin_o
);

    localparam int IDX_W = idx_w(N_IRQ);

    irq_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] rr_ptr;
    logic [N_IRQ-1:0] pending;
    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;

    // Only the low N_IRQ mie bits map to interrupt lines.
    assign pending = int_req_i & mie_i[N_IRQ-1:0];

    logic mie_unused;
    assign mie_unused = ^mie_i[31:N_IRQ];

    irq_arbiter #(
        .N_IRQ (N_IRQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .valid   (arb_valid),
        .index   (arb_idx)
    );

`ifdef INTERRUPT_ROUND_ROBIN_EN
    // Remember the last winner so the next search starts just after it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            rr_ptr <= IDX_W'(N_IRQ - 1);
        else if (state_q == IDLE && arb_valid)
            rr_ptr <= arb_idx;
    end
`else
    assign rr_ptr = IDX_W'(N_IRQ - 1);
`endif

    // Sequencer with registered strobe and cause; no nesting while serviced.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            int_o    <= 1'b0;
            mcause_o <= '0;
        end else begin
            int_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // mret here has nothing to complete and is dropped.
                    if (arb_valid) begin
                        idx_q    <= arb_idx;
                        mcause_o <= CAUSE_BASE + 32'(arb_idx);
                        int_o    <= 1'b1;
                        state_q  <= TRAP;
                    end
                end
                // The core cannot retire mret before taking the trap.
                TRAP:    state_q <= SERVICE;
                // Request or mie changes here never cancel; only mret ends it.
                SERVICE: if (mret_i) state_q <= FIN;
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Completion is decoded from registered state only.
    assign int_fin_o = (state_q == FIN) ? (N_IRQ'(1) << idx_q) : '0;

endmodule
